// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters.
// Grants one requester, acks it, pulses data_valid, then waits for the frame to finish.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_par_en,
    input  logic [NUM_REQ-1:0]   req_par_typ,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 tx_busy,
    output logic [7:0]           tx_p_data,
    output logic                 tx_data_valid,
    output logic                 tx_par_en,
    output logic                 tx_par_typ,
    output logic [IW-1:0]        grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t               state_r, state_nx_s;
    logic [IW-1:0]        ptr_r, ptr_nx_s, win_s;
    logic                 found_s;
    logic [CW-1:0]        cnt_r, cnt_nx_s;
    logic                 tmo_s;
    logic                 load_s;
    logic [NUM_REQ-1:0]   ack_nx_s;
    logic                 dv_nx_s, active_nx_s, terr_nx_s;

    // Returns {found, index}; scanned downward so the smallest offset from ptr wins.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IW-1:0] ptr);
        logic [IW:0] res;
        logic [IW:0] idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + IW1'(i);
            if (idx >= IW1'(NUM_REQ)) begin
                idx = idx - IW1'(NUM_REQ);
            end else begin
                idx = idx;
            end
            if (valid[idx[IW-1:0]]) begin
                res = {1'b1, idx[IW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign {found_s, win_s} = rr_pick(req_valid, ptr_r);

    // State, round-robin pointer and WAIT_HI counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            ptr_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state, pointer advance and timeout counter logic
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        cnt_nx_s   = cnt_r;
        tmo_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (found_s) begin
                    state_nx_s = S_GRANT;
                    ptr_nx_s   = (win_s == IW'(NUM_REQ - 1)) ? '0 : win_s + 1'b1;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_GRANT: state_nx_s = S_ISSUE;
            S_ISSUE: begin
                state_nx_s = S_WAIT_HI;
                cnt_nx_s   = '0;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_nx_s = S_WAIT_LO;
                end else if (cnt_r == TO_LAST) begin
                    // counter would reach TIMEOUT-1: drop the byte without retry
                    state_nx_s = S_IDLE;
                    cnt_nx_s   = cnt_r + 1'b1;
                    tmo_s      = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (tx_busy) begin
                    state_nx_s = S_WAIT_LO;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        load_s = (state_r == S_IDLE) && found_s;
        if (load_s) begin
            ack_nx_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            ack_nx_s = '0;
        end
        dv_nx_s     = (state_nx_s == S_ISSUE);
        active_nx_s = (state_nx_s != S_IDLE);
        terr_nx_s   = tmo_s;
    end

    // Output registers; byte and parity config only change on a new grant
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ack       <= '0;
            tx_data_valid <= 1'b0;
            active        <= 1'b0;
            timeout_err   <= 1'b0;
            tx_p_data     <= 8'h00;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= 1'b0;
            grant_id      <= '0;
        end else begin
            req_ack       <= ack_nx_s;
            tx_data_valid <= dv_nx_s;
            active        <= active_nx_s;
            timeout_err   <= terr_nx_s;
            if (load_s) begin
                tx_p_data  <= req_data[8*int'(win_s) +: 8];
                tx_par_en  <= req_par_en[win_s];
                tx_par_typ <= req_par_typ[win_s];
                grant_id   <= win_s;
            end else begin
                tx_p_data  <= tx_p_data;
                tx_par_en  <= tx_par_en;
                tx_par_typ <= tx_par_typ;
                grant_id   <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=4).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_par_en;
    logic [3:0]  req_par_typ;
    logic [3:0]  req_ack;
    logic        tx_busy;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_par_en;
    logic        tx_par_typ;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int cmp_cnt = 0;
    int err_cnt = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .req_ack(req_ack), .tx_busy(tx_busy),
        .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
        .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ),
        .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Returns number of negedges waited before tx_data_valid, or -1 if none within budget.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_data_valid === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    // Acts as the transmitter: busy rises in the first WAIT_HI cycle and lasts len cycles.
    task automatic busy_frame(input int len);
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if ({req_ack, tx_data_valid, active, timeout_err, grant_id} !== 9'h000) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %h expected 000", {req_ack, tx_data_valid, active, timeout_err, grant_id});
        end
        cmp_cnt++;
        if ({tx_p_data, tx_par_en, tx_par_typ} !== 10'h000) begin
            err_cnt++;
            $display("FAIL reset_data: got %h expected 000", {tx_p_data, tx_par_en, tx_par_typ});
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        req_data[7:0] = 8'hA5; req_par_en = 4'b0001; req_par_typ = 4'b0000;
        req_valid = 4'b0001;
        @(negedge clk);
        cmp_cnt++;
        if ({req_ack, active} !== 5'b00000) begin
            err_cnt++;
            $display("FAIL single_k: got %b expected 00000", {req_ack, active});
        end
        @(negedge clk);
        cmp_cnt++;
        if ({req_ack, active, tx_data_valid, grant_id} !== 8'b0001_1_0_00) begin
            err_cnt++;
            $display("FAIL single_ack: got %b expected 00011000", {req_ack, active, tx_data_valid, grant_id});
        end
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        cmp_cnt++;
        if ({tx_data_valid, req_ack, tx_p_data, tx_par_en, tx_par_typ} !== {1'b1, 4'b0000, 8'hA5, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL single_issue: got %h expected %h", {tx_data_valid, req_ack, tx_p_data, tx_par_en, tx_par_typ},
                     {1'b1, 4'b0000, 8'hA5, 1'b1, 1'b0});
        end
        busy_frame(4);
        @(negedge clk);
        cmp_cnt++;
        if ({active, tx_data_valid, tx_p_data, tx_par_en} !== {1'b1, 1'b0, 8'hA5, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_waitlo: got %h expected %h", {active, tx_data_valid, tx_p_data, tx_par_en}, {1'b1, 1'b0, 8'hA5, 1'b1});
        end
        @(negedge clk);
        cmp_cnt++;
        if ({active, grant_id} !== 3'b000) begin
            err_cnt++;
            $display("FAIL single_idle: got %b expected 000", {active, grant_id});
        end
    endtask

    task automatic test_contention;
        int n;
        @(posedge clk); #1;
        req_data = 32'h44_33_22_11; req_par_en = 4'b0000; req_par_typ = 4'b0000;
        req_valid = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if ({req_ack, grant_id} !== 6'b0010_01) begin
            err_cnt++;
            $display("FAIL cont_ack1: got %b expected 001001", {req_ack, grant_id});
        end
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_valid(n);
        cmp_cnt++;
        if ({n[7:0], tx_p_data} !== {8'd0, 8'h22}) begin
            err_cnt++;
            $display("FAIL cont_frame1: got n=%0d data=%h expected n=0 data=22", n, tx_p_data);
        end
        busy_frame(3);
        wait_valid(n);
        cmp_cnt++;
        if ({n[7:0], grant_id, tx_p_data} !== {8'd3, 2'd2, 8'h33}) begin
            err_cnt++;
            $display("FAIL cont_frame2: got n=%0d id=%0d data=%h expected n=3 id=2 data=33", n, grant_id, tx_p_data);
        end
        req_valid = 4'b0000;
        busy_frame(2);
        @(negedge clk);
        @(negedge clk);
        // pointer now 3: with 0 and 3 both pending, 3 must win
        @(posedge clk); #1 req_valid = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if ({req_ack, grant_id} !== 6'b1000_11) begin
            err_cnt++;
            $display("FAIL cont_ptr3: got %b expected 100011", {req_ack, grant_id});
        end
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_valid(n);
        busy_frame(1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_fairness;
        int n;
        logic [1:0] exp_id;
        logic [7:0] exp_d;
        @(posedge clk); #1;
        req_data = 32'h13_12_11_10;
        req_valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            exp_id = 2'(f % 4);
            exp_d  = 8'h10 + 8'(f % 4);
            wait_valid(n);
            if (f == 7) req_valid = 4'b0000;
            cmp_cnt++;
            if ({grant_id, tx_p_data} !== {exp_id, exp_d} || n < 0) begin
                err_cnt++;
                $display("FAIL fair_%0d: got id=%0d data=%h n=%0d expected id=%0d data=%h", f, grant_id, tx_p_data, n, exp_id, exp_d);
            end
            busy_frame(2);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        @(posedge clk); #1;
        req_data = 32'h00_00_B2_B1;
        req_valid = 4'b0011;
        wait_valid(n);
        cmp_cnt++;
        if ({n[7:0], grant_id, tx_p_data} !== {8'd2, 2'd0, 8'hB1}) begin
            err_cnt++;
            $display("FAIL tmo_issue: got n=%0d id=%0d data=%h expected n=2 id=0 data=b1", n, grant_id, tx_p_data);
        end
        req_valid = 4'b0010;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({timeout_err, active} !== {(i == 4), (i < 4)}) begin
                err_cnt++;
                $display("FAIL tmo_cyc%0d: got err=%b active=%b expected err=%b active=%b", i, timeout_err, active, (i == 4), (i < 4));
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if ({req_ack, grant_id, timeout_err} !== {4'b0010, 2'd1, 1'b0}) begin
            err_cnt++;
            $display("FAIL tmo_next: got %b expected 0010010", {req_ack, grant_id, timeout_err});
        end
        req_valid = 4'b0000;
        wait_valid(n);
        cmp_cnt++;
        if ({n[7:0], tx_p_data} !== {8'd0, 8'hB2}) begin
            err_cnt++;
            $display("FAIL tmo_served: got n=%0d data=%h expected n=0 data=b2", n, tx_p_data);
        end
        busy_frame(1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        @(posedge clk); #1;
        req_data = 32'h00_C2_C1_00;
        req_valid = 4'b0010;
        wait_valid(n);
        req_valid = 4'b0000;
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (active !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_pre: got active=%b expected 1", active);
        end
        @(posedge clk); #1 rst = 1'b1; tx_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if ({active, tx_data_valid, req_ack, timeout_err, grant_id, tx_p_data} !== 17'h0) begin
            err_cnt++;
            $display("FAIL rstmid_out: got %h expected 0", {active, tx_data_valid, req_ack, timeout_err, grant_id, tx_p_data});
        end
        @(posedge clk); #1 rst = 1'b0; req_valid = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        // pointer back at 0 so requester 1 wins over 2
        cmp_cnt++;
        if ({req_ack, grant_id} !== 6'b0010_01) begin
            err_cnt++;
            $display("FAIL rstmid_ptr: got %b expected 001001", {req_ack, grant_id});
        end
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_valid(n);
        busy_frame(1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_stability;
        int n;
        @(posedge clk); #1;
        req_data[7:0] = 8'h3C; req_par_en = 4'b0000; req_par_typ = 4'b0001;
        req_valid = 4'b0001;
        wait_valid(n);
        cmp_cnt++;
        if ({n[7:0], grant_id, tx_p_data, tx_par_en, tx_par_typ} !== {8'd2, 2'd0, 8'h3C, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL stab_issue: got n=%0d id=%0d data=%h pe=%b pt=%b expected n=2 id=0 data=3c pe=0 pt=1",
                     n, grant_id, tx_p_data, tx_par_en, tx_par_typ);
        end
        req_valid = 4'b0000; req_data[7:0] = 8'hFF; req_par_en = 4'b0001; req_par_typ = 4'b0000;
        @(posedge clk); #1 tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                @(posedge clk); #1 tx_busy = 1'b0;
            end
            @(negedge clk);
            cmp_cnt++;
            if ({tx_p_data, tx_par_en, tx_par_typ, active} !== {8'h3C, 1'b0, 1'b1, 1'b1}) begin
                err_cnt++;
                $display("FAIL stab_cyc%0d: got %h expected %h", i, {tx_p_data, tx_par_en, tx_par_typ, active}, {8'h3C, 1'b0, 1'b1, 1'b1});
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (active !== 1'b0) begin
            err_cnt++;
            $display("FAIL stab_idle: got active=%b expected 0", active);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0000; req_data = 32'h0; req_par_en = 4'b0000; req_par_typ = 4'b0000;
        tx_busy = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_stability();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
